// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler between the instruction FIFO
// and the master/slave decode lanes, with load-use and branch tracking.
module issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic       fifo_almost_empty,
  input  logic       pipe_stall,
  input  logic       exception_flush,
  input  logic       branch_taken,
  input  logic [4:0] m_rs,
  input  logic [4:0] m_rt,
  input  logic [4:0] m_wb_reg_dest,
  input  logic       m_wb_reg_en,
  input  logic       m_is_load,
  input  logic       m_is_mem,
  input  logic       m_is_branch,
  input  logic       m_is_hilo,
  input  logic       m_priv,
  input  logic [4:0] s_rs,
  input  logic [4:0] s_rt,
  input  logic [4:0] s_wb_reg_dest,
  input  logic       s_wb_reg_en,
  input  logic       s_is_load,
  input  logic       s_is_mem,
  input  logic       s_is_branch,
  input  logic       s_is_hilo,
  input  logic       s_priv,
  output logic       read_en1,
  output logic       read_en2,
  output logic       fifo_flush,
  output logic       dual_issue
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_DS,
    WAIT_RES,
    FLUSH
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  state_t     w_br_nx;
  logic [4:0] r_ld_dest;
  logic [4:0] w_ld_nx;
  logic       r_taken_q;
  logic       r_dual;

  logic w_ld_vld;
  logic w_hz_m;
  logic w_hz_s;
  logic w_raw;
  logic w_res_taken;
  logic w_can_issue;
  logic w_pair_ok;
  logic w_issue_m;
  logic w_issue_s;

  assign w_ld_vld = (r_ld_dest != 5'd0);
  assign w_hz_m = w_ld_vld &&
    ((r_ld_dest == m_rs) || (r_ld_dest == m_rt));
  assign w_hz_s = w_ld_vld &&
    ((r_ld_dest == s_rs) || (r_ld_dest == s_rt));
  assign w_raw = m_wb_reg_en && (m_wb_reg_dest != 5'd0) &&
    ((m_wb_reg_dest == s_rs) || (m_wb_reg_dest == s_rt));

  assign w_res_taken = (r_state == WAIT_RES) &&
    (branch_taken || r_taken_q);
  assign w_can_issue = !exception_flush &&
    (r_state != FLUSH) && !w_res_taken;

  assign w_issue_m = w_can_issue && !fifo_empty &&
    !pipe_stall && !w_hz_m;

  assign w_pair_ok = !fifo_almost_empty && !w_raw &&
    !(m_is_mem && s_is_mem) && !(m_is_hilo && s_is_hilo) &&
    !s_is_branch && !s_priv && !m_priv && !w_hz_s;

  // The delay slot of a lone branch must issue by itself.
  assign w_issue_s = w_issue_m && w_pair_ok &&
    (r_state != WAIT_DS);

  assign read_en1   = w_issue_m;
  assign read_en2   = w_issue_s;
  assign fifo_flush = exception_flush || (r_state == FLUSH);
  assign dual_issue = r_dual;

  // Load destination carried into the next cycle's hazard check.
  always_comb begin
    w_ld_nx = 5'd0;
    if (w_issue_s && s_is_load && s_wb_reg_en)
      w_ld_nx = s_wb_reg_dest;
    else if (w_issue_m && m_is_load && m_wb_reg_en)
      w_ld_nx = m_wb_reg_dest;
  end

  // Next state; a branch with its slot paired skips WAIT_DS.
  always_comb begin
    w_br_nx = RUN;
    if (w_issue_m && m_is_branch)
      w_br_nx = w_issue_s ? WAIT_RES : WAIT_DS;
    w_state_nx = r_state;
    case (r_state)
      RUN:      w_state_nx = w_br_nx;
      WAIT_DS:  w_state_nx = w_issue_m ? WAIT_RES : WAIT_DS;
      WAIT_RES: w_state_nx = w_res_taken ? FLUSH : w_br_nx;
      FLUSH:    w_state_nx = RUN;
      default:  w_state_nx = RUN;
    endcase
  end

  // State, hazard and branch-resolution registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_ld_dest <= 5'd0;
      r_taken_q <= 1'b0;
      r_dual    <= 1'b0;
    end else if (exception_flush) begin
      r_state   <= RUN;
      r_ld_dest <= 5'd0;
      r_taken_q <= 1'b0;
      r_dual    <= 1'b0;
    end else begin
      r_dual <= w_issue_s;
      if (!pipe_stall)
        r_ld_dest <= w_ld_nx;
      if (r_state == FLUSH) begin
        r_state   <= RUN;
        r_taken_q <= 1'b0;
      end else begin
        if (!pipe_stall)
          r_state <= w_state_nx;
        if (((r_state == WAIT_DS) || (r_state == WAIT_RES)) &&
            branch_taken)
          r_taken_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the scheduler.
module tb_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_almost_empty = 1'b0;
  logic       pipe_stall = 1'b0;
  logic       exception_flush = 1'b0;
  logic       branch_taken = 1'b0;
  logic [4:0] m_rs = '0, m_rt = '0, m_wb_reg_dest = '0;
  logic       m_wb_reg_en = 0, m_is_load = 0, m_is_mem = 0;
  logic       m_is_branch = 0, m_is_hilo = 0, m_priv = 0;
  logic [4:0] s_rs = '0, s_rt = '0, s_wb_reg_dest = '0;
  logic       s_wb_reg_en = 0, s_is_load = 0, s_is_mem = 0;
  logic       s_is_branch = 0, s_is_hilo = 0, s_priv = 0;
  logic       read_en1, read_en2, fifo_flush, dual_issue;

  int n_vec = 0;
  int n_err = 0;

  issue_ctrl dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .pipe_stall(pipe_stall),
    .exception_flush(exception_flush),
    .branch_taken(branch_taken),
    .m_rs(m_rs), .m_rt(m_rt), .m_wb_reg_dest(m_wb_reg_dest),
    .m_wb_reg_en(m_wb_reg_en), .m_is_load(m_is_load),
    .m_is_mem(m_is_mem), .m_is_branch(m_is_branch),
    .m_is_hilo(m_is_hilo), .m_priv(m_priv),
    .s_rs(s_rs), .s_rt(s_rt), .s_wb_reg_dest(s_wb_reg_dest),
    .s_wb_reg_en(s_wb_reg_en), .s_is_load(s_is_load),
    .s_is_mem(s_is_mem), .s_is_branch(s_is_branch),
    .s_is_hilo(s_is_hilo), .s_priv(s_priv),
    .read_en1(read_en1), .read_en2(read_en2),
    .fifo_flush(fifo_flush), .dual_issue(dual_issue)
  );

  always #5 clk = ~clk;

  // Model: pending obligations rather than a state encoding.
  int md_ld = 0;
  bit md_need_slot = 0;
  bit md_resolve = 0;
  bit md_flush = 0;
  bit md_seen_taken = 0;
  bit md_dual = 0;

  function automatic bit reads(int r, logic [4:0] a, logic [4:0] b);
    return (r != 0) && (r == int'(a) || r == int'(b));
  endfunction

  function automatic void model_outs(output bit e1, e2, ef);
    bit kill;
    bit raw;
    ef = exception_flush || md_flush;
    kill = exception_flush || md_flush ||
      (md_resolve && (branch_taken || md_seen_taken));
    e1 = !kill && !fifo_empty && !pipe_stall &&
      !reads(md_ld, m_rs, m_rt);
    raw = m_wb_reg_en && m_wb_reg_dest != 0 &&
      (m_wb_reg_dest == s_rs || m_wb_reg_dest == s_rt);
    e2 = e1 && !md_need_slot && !fifo_almost_empty && !raw &&
      !(m_is_mem && s_is_mem) && !(m_is_hilo && s_is_hilo) &&
      !s_is_branch && !s_priv && !m_priv &&
      !reads(md_ld, s_rs, s_rt);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit e1, e2, ef;
    if (!rst) begin
      md_ld = 0; md_need_slot = 0; md_resolve = 0;
      md_flush = 0; md_seen_taken = 0; md_dual = 0;
    end else begin
      model_outs(e1, e2, ef);
      md_dual = e2;
      if (exception_flush) begin
        md_ld = 0; md_need_slot = 0; md_resolve = 0;
        md_flush = 0; md_seen_taken = 0;
      end else if (md_flush) begin
        md_flush = 0;
        md_seen_taken = 0;
        if (!pipe_stall) md_ld = 0;
      end else if (pipe_stall) begin
        if ((md_need_slot || md_resolve) && branch_taken)
          md_seen_taken = 1;
      end else begin
        if (md_need_slot) begin
          if (branch_taken) md_seen_taken = 1;
          if (e1) begin
            md_need_slot = 0;
            md_resolve = 1;
          end
        end else begin
          if (md_resolve) begin
            md_resolve = 0;
            if (branch_taken || md_seen_taken) md_flush = 1;
          end
          if (e1 && m_is_branch) begin
            if (e2) md_resolve = 1;
            else md_need_slot = 1;
          end
        end
        if (e2 && s_is_load && s_wb_reg_en) md_ld = s_wb_reg_dest;
        else if (e1 && m_is_load && m_wb_reg_en) md_ld = m_wb_reg_dest;
        else md_ld = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_empty = 1; fifo_almost_empty = 0;
    pipe_stall = 0; exception_flush = 0; branch_taken = 0;
    m_rs = 0; m_rt = 0; m_wb_reg_dest = 0; m_wb_reg_en = 0;
    m_is_load = 0; m_is_mem = 0; m_is_branch = 0;
    m_is_hilo = 0; m_priv = 0;
    s_rs = 0; s_rt = 0; s_wb_reg_dest = 0; s_wb_reg_en = 0;
    s_is_load = 0; s_is_mem = 0; s_is_branch = 0;
    s_is_hilo = 0; s_priv = 0;
  endtask

  task automatic alu_pair();
    fifo_empty = 0; fifo_almost_empty = 0;
    m_rs = 1; m_rt = 2; m_wb_reg_dest = 5; m_wb_reg_en = 1;
    s_rs = 6; s_rt = 7; s_wb_reg_dest = 8; s_wb_reg_en = 1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush, dual_issue} !== 4'b0) begin
      n_err++;
      $display("FAIL reset outs got %b want 0000",
        {read_en1, read_en2, fifo_flush, dual_issue});
    end
    #10 rst = 1;
    cyc();
  endtask

  task automatic test_alu_pair();
    idle(); alu_pair(); #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b11) begin
      n_err++;
      $display("FAIL alu_pair pops got %b want 11", {read_en1, read_en2});
    end
    cyc(); idle(); #1;
    n_vec++;
    if (dual_issue !== 1'b1) begin
      n_err++;
      $display("FAIL alu_pair dual got %b want 1", dual_issue);
    end
    cyc();
  endtask

  task automatic test_load_use();
    idle(); alu_pair();
    m_rt = 0; m_wb_reg_dest = 3; m_is_load = 1; m_is_mem = 1;
    s_rs = 3;
    #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b10) begin
      n_err++;
      $display("FAIL lu_raw pops got %b want 10", {read_en1, read_en2});
    end
    cyc(); idle(); alu_pair(); m_rs = 3; #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b00) begin
      n_err++;
      $display("FAIL lu_bubble pops got %b want 00",
        {read_en1, read_en2});
    end
    cyc(); #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b11) begin
      n_err++;
      $display("FAIL lu_after pops got %b want 11", {read_en1, read_en2});
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_branch_pair_taken();
    idle(); alu_pair();
    m_is_branch = 1; m_wb_reg_en = 0; m_wb_reg_dest = 0;
    #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b11) begin
      n_err++;
      $display("FAIL br_pair pops got %b want 11", {read_en1, read_en2});
    end
    cyc(); idle(); alu_pair(); branch_taken = 1; #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b000) begin
      n_err++;
      $display("FAIL br_res outs got %b want 000",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); branch_taken = 0; #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b001) begin
      n_err++;
      $display("FAIL br_flush outs got %b want 001",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b110) begin
      n_err++;
      $display("FAIL br_run outs got %b want 110",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_branch_ds();
    idle(); fifo_empty = 0; fifo_almost_empty = 1;
    m_is_branch = 1; m_rs = 1; m_rt = 2;
    #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b10) begin
      n_err++;
      $display("FAIL ds_br pops got %b want 10", {read_en1, read_en2});
    end
    cyc(); idle(); branch_taken = 1; #1;
    n_vec++;
    if ({read_en1, fifo_flush} !== 2'b00) begin
      n_err++;
      $display("FAIL ds_wait outs got %b want 00", {read_en1, fifo_flush});
    end
    cyc(); branch_taken = 0; cyc(); cyc();
    alu_pair(); #1;
    n_vec++;
    if ({read_en1, read_en2} !== 2'b10) begin
      n_err++;
      $display("FAIL ds_slot pops got %b want 10", {read_en1, read_en2});
    end
    cyc(); #1;
    n_vec++;
    if ({read_en1, fifo_flush} !== 2'b00) begin
      n_err++;
      $display("FAIL ds_res outs got %b want 00", {read_en1, fifo_flush});
    end
    cyc(); #1;
    n_vec++;
    if ({read_en1, fifo_flush} !== 2'b01) begin
      n_err++;
      $display("FAIL ds_flush outs got %b want 01", {read_en1, fifo_flush});
    end
    cyc(); #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b110) begin
      n_err++;
      $display("FAIL ds_run outs got %b want 110",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_single_issue();
    logic [1:0] got [4];
    idle(); alu_pair(); m_is_mem = 1; s_is_mem = 1; #1;
    got[0] = {read_en1, read_en2};
    cyc(); idle(); alu_pair(); m_priv = 1; #1;
    got[1] = {read_en1, read_en2};
    cyc(); idle(); alu_pair(); m_is_hilo = 1; s_is_hilo = 1; #1;
    got[2] = {read_en1, read_en2};
    cyc(); idle(); alu_pair(); fifo_almost_empty = 1; #1;
    got[3] = {read_en1, read_en2};
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got[i] !== 2'b10) begin
        n_err++;
        $display("FAIL single_%0d pops got %b want 10", i, got[i]);
      end
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_exception();
    idle(); fifo_empty = 0; fifo_almost_empty = 1; m_is_branch = 1;
    cyc();
    idle(); alu_pair(); pipe_stall = 1; exception_flush = 1; #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b001) begin
      n_err++;
      $display("FAIL exc outs got %b want 001",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); pipe_stall = 0; exception_flush = 0; #1;
    n_vec++;
    if ({read_en1, read_en2, fifo_flush} !== 3'b110) begin
      n_err++;
      $display("FAIL exc_run outs got %b want 110",
        {read_en1, read_en2, fifo_flush});
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_async_reset();
    idle(); alu_pair(); m_is_load = 1; m_is_mem = 1; m_wb_reg_dest = 3;
    cyc();
    idle(); alu_pair(); m_rs = 3; #1;
    n_vec++;
    if (read_en1 !== 1'b0) begin
      n_err++;
      $display("FAIL ar_hazard re1 got %b want 0", read_en1);
    end
    rst = 0; #1;
    n_vec++;
    if ({dual_issue, read_en1, read_en2} !== 3'b011) begin
      n_err++;
      $display("FAIL ar_clear outs got %b want 011",
        {dual_issue, read_en1, read_en2});
    end
    #1 rst = 1;
    cyc(); idle(); cyc();
  endtask

  task automatic test_random();
    bit e1, e2, ef;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 5);
      fifo_empty = (r == 0);
      fifo_almost_empty = (r == 1);
      pipe_stall = ($urandom_range(0, 5) == 0);
      exception_flush = ($urandom_range(0, 40) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      m_rs = 5'($urandom_range(0, 7));
      m_rt = 5'($urandom_range(0, 7));
      m_wb_reg_dest = 5'($urandom_range(0, 7));
      m_is_load = ($urandom_range(0, 3) == 0);
      m_is_mem = m_is_load | ($urandom_range(0, 4) == 0);
      m_wb_reg_en = m_is_load | ($urandom_range(0, 1) == 1);
      m_is_branch = ($urandom_range(0, 4) == 0);
      m_is_hilo = ($urandom_range(0, 4) == 0);
      m_priv = ($urandom_range(0, 12) == 0);
      s_rs = 5'($urandom_range(0, 7));
      s_rt = 5'($urandom_range(0, 7));
      s_wb_reg_dest = 5'($urandom_range(0, 7));
      s_is_load = ($urandom_range(0, 3) == 0);
      s_is_mem = s_is_load | ($urandom_range(0, 4) == 0);
      s_wb_reg_en = s_is_load | ($urandom_range(0, 1) == 1);
      s_is_branch = ($urandom_range(0, 6) == 0);
      s_is_hilo = ($urandom_range(0, 4) == 0);
      s_priv = ($urandom_range(0, 12) == 0);
      #1;
      model_outs(e1, e2, ef);
      n_vec++;
      if ({read_en1, read_en2, fifo_flush, dual_issue} !==
          {e1, e2, ef, md_dual}) begin
        n_err++;
        $display("FAIL rand_%0d re1/re2/flush/dual got %b want %b", i,
          {read_en1, read_en2, fifo_flush, dual_issue},
          {e1, e2, ef, md_dual});
      end
      cyc();
    end
    idle(); cyc();
  endtask

  initial begin
    test_reset();
    test_alu_pair();
    test_load_use();
    test_branch_pair_taken();
    test_branch_ds();
    test_single_issue();
    test_exception();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
